mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 22 ++
 rtl/mem_responder_if.sv | 40 ++++
 rtl/mem_responder_byte_assembler.sv | 43 ++++
 rtl/mem_responder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the boot-loading memory responder: widths, default
// depth, controller states and the word-index width helper.
package mem_pkg;

  localparam int DATA_W        = 32;
  localparam int BYTE_W        = 8;
  localparam int DEPTH_DEFAULT = 256;
  localparam int IDX_W_DEFAULT = $clog2(DEPTH_DEFAULT);

  // LOAD: core held in reset while the boot image streams in.
  // RUN : core owns the memory; loader input ignored until the next reset.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Word-index width for a given depth; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core data-bus and boot-byte stream bundled as one interface. The master
// side is the core/boot source, the slave side is the memory responder.
interface mem_responder_if;
  import mem_pkg::*;

  // Core load/store port
  logic [DATA_W-1:0] address_to_mem;
  logic [DATA_W-1:0] data_to_mem;
  logic              WE;
  logic [DATA_W-1:0] data_from_mem;

  // Boot byte stream
  logic              load_valid;
  logic [BYTE_W-1:0] load_byte;
  logic              load_last;
  logic              load_ready;

  modport master (
    output address_to_mem,
    output data_to_mem,
    output WE,
    input  data_from_mem,
    output load_valid,
    output load_byte,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  address_to_mem,
    input  data_to_mem,
    input  WE,
    output data_from_mem,
    input  load_valid,
    input  load_byte,
    input  load_last,
    output load_ready
  );

endinterface

// File: rtl/mem_responder_byte_assembler.sv
// Packs accepted boot bytes little-endian into 32-bit words. A word is
// complete after the fourth byte or on the image's final byte, in which case
// the upper bytes not yet filled remain zero.
module byte_assembler
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              last,
  output logic              word_done,
  output logic [DATA_W-1:0] word
);

  logic [1:0]        cnt_q;
  logic [DATA_W-1:0] asm_q;

  assign word_done = accept && ((cnt_q == 2'd3) || last);

  // Current byte merged into its lane; lanes above it are still zero because
  // the assembly register is cleared whenever a word completes.
  always_comb begin
    word = asm_q | (DATA_W'(byte_in) << {cnt_q, 3'b000});
  end

  // Byte position and partial word; reset discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
      asm_q <= '0;
    end else if (accept) begin
      if (word_done) begin
        cnt_q <= 2'd0;
        asm_q <= '0;
      end else begin
        cnt_q <= cnt_q + 2'd1;
        asm_q <= word;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: after reset it holds the core in reset while a boot
// image streams in byte by byte, then releases the core and serves its
// word loads/stores from the same single-write-port memory.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  output logic            core_reset,
  output logic            misalign,
  output logic            overflow
);

  localparam int                IDX_W      = idx_width(DEPTH);
  localparam int                PTR_W      = IDX_W + 1;
  localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(4 * DEPTH);
  localparam logic [PTR_W-1:0]  PTR_FULL   = PTR_W'(DEPTH);

  state_t            state_q;
  logic [PTR_W-1:0]  load_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              word_done;
  logic [DATA_W-1:0] word;
  logic              ptr_full;
  logic              in_range;
  logic              aligned;
  logic [IDX_W-1:0]  core_idx;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  // Handshake and core hold are pure decodes of the state register.
  assign bus.load_ready = (state_q == LOAD);
  assign core_reset     = (state_q == LOAD);

  assign accept   = bus.load_valid && (state_q == LOAD);
  assign ptr_full = (load_ptr_q == PTR_FULL);
  assign in_range = (bus.address_to_mem < ADDR_LIMIT);
  assign aligned  = (bus.address_to_mem[1:0] == 2'b00);
  assign core_idx = bus.address_to_mem[IDX_W+1:2];

  byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .byte_in   (bus.load_byte),
    .last      (bus.load_last),
    .word_done (word_done),
    .word      (word)
  );

  // Single write port: the loader owns it in LOAD, the core in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (state_q == LOAD) begin
      wr_en   = word_done && !ptr_full;
      wr_idx  = load_ptr_q[IDX_W-1:0];
      wr_data = word;
    end else begin
      wr_en   = bus.WE && in_range && aligned;
      wr_idx  = core_idx;
      wr_data = bus.data_to_mem;
    end
  end

  // Asynchronous read; out-of-range addresses and the LOAD phase read zero.
  always_comb begin
    bus.data_from_mem = '0;
    if ((state_q == RUN) && in_range) begin
      bus.data_from_mem = mem_q[core_idx];
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Controller: LOAD/RUN state, load pointer and the two sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      load_ptr_q <= '0;
      misalign   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (word_done) begin
            if (ptr_full) begin
              overflow <= 1'b1;
            end else begin
              load_ptr_q <= load_ptr_q + PTR_W'(1);
            end
          end
          if (accept && bus.load_last) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (bus.WE && !aligned) begin
            misalign <= 1'b1;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule
